quad_motor_ctrl: RTL

- Multi-channel DC-motor controller with quadrature position decoding, generalised from the single-channel motor FSM.
- Sits on the address/strobe/ready peripheral bus. Provides, per channel:
  - an H-bridge drive pair (CW/CCW/stop);
  - a 4x quadrature position counter;
  - sensed-direction readback;
  - a movement interrupt and a sticky illegal-transition error flag.

---
 rtl/quad_motor_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/quad_motor_ctrl.sv
// Multi-channel H-bridge motor controller with 4x quadrature position counters,
// accessed over the address/strobe/ready peripheral bus (one action per strobe).
module quad_motor_ctrl #(
    parameter int                NUM_CH      = 2,
    parameter int                CNT_W       = 16,
    parameter int                ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 12'h100,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] add,
    input  logic              strobe,
    output logic              ready,
    output logic [CNT_W-1:0]  rd_data,
    input  logic [NUM_CH-1:0] cha,
    input  logic [NUM_CH-1:0] chb,
    output logic [NUM_CH-1:0] motor_red,
    output logic [NUM_CH-1:0] motor_black,
    output logic              interrupt
);
    localparam int                CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W-5:0] NUM_BLK = (ADDR_W-4)'(NUM_CH);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACK = 2'd1, ST_DONE = 2'd2} state_t;

    // Phase distance along the CW sequence 00,01,11,10: 1 = CW, 3 = CCW, 2 = illegal
    function automatic logic [1:0] step_delta(input logic cur_a, input logic cur_b,
                                              input logic prv_a, input logic prv_b);
        return {cur_a, cur_a ^ cur_b} - {prv_a, prv_a ^ prv_b};
    endfunction

    state_t             state_r, next_state_s;
    logic               ready_r;
    logic [CNT_W-1:0]   rd_data_r, rd_next_s;
    logic [CH_W-1:0]    ch_r;
    logic [3:0]         off_r;
    logic [ADDR_W-1:0]  rel_s;
    logic               hit_s, off_ok_s;
    logic [NUM_CH-1:0]  red_r, black_r, red_next_s, black_next_s;
    logic [NUM_CH-1:0]  clr_pos_s, clr_flag_s, inc_s, dec_s, bad_s;
    logic [NUM_CH-1:0]  a_sync_r [SYNC_STAGES];
    logic [NUM_CH-1:0]  b_sync_r [SYNC_STAGES];
    logic [NUM_CH-1:0]  a_prev_r, b_prev_r;
    logic [CNT_W-1:0]   pos_r [NUM_CH];
    logic [NUM_CH-1:0]  dir_r, pend_r, err_r;
    logic               int_r;

    // Address decode: channel block in range and a defined register offset
    always_comb begin
        rel_s = add - BASE_ADDR;
        case (rel_s[3:0])
            4'h0, 4'h1, 4'h2, 4'hC, 4'hD, 4'hE, 4'hF: off_ok_s = 1'b1;
            default:                                  off_ok_s = 1'b0;
        endcase
        hit_s = (add >= BASE_ADDR) && (rel_s[ADDR_W-1:4] < NUM_BLK) && off_ok_s;
    end

    // Handshake next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!strobe && hit_s) next_state_s = ST_ACK;
                else                  next_state_s = ST_IDLE;
            end
            ST_ACK:  next_state_s = ST_DONE;
            ST_DONE: begin
                if (strobe) next_state_s = ST_IDLE;
                else        next_state_s = ST_DONE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Handshake state, ready and the decode captured on entry to ACK
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            ch_r    <= '0;
            off_r   <= 4'h0;
        end else begin
            state_r <= next_state_s;
            ready_r <= (next_state_s != ST_ACK);
            if ((state_r == ST_IDLE) && (next_state_s == ST_ACK)) begin
                ch_r  <= rel_s[4 +: CH_W];
                off_r <= rel_s[3:0];
            end
        end
    end

    // Register action applied in ACK; reads see values from before this edge
    always_comb begin
        clr_pos_s    = '0;
        clr_flag_s   = '0;
        red_next_s   = red_r;
        black_next_s = black_r;
        rd_next_s    = rd_data_r;
        if (state_r == ST_ACK) begin
            case (off_r)
                4'h0: rd_next_s = pos_r[ch_r];
                4'h1: begin rd_next_s = '0; clr_pos_s[ch_r]  = 1'b1; end
                4'h2: begin rd_next_s = '0; clr_flag_s[ch_r] = 1'b1; end
                4'hC: begin rd_next_s = '0; red_next_s[ch_r] = 1'b1; black_next_s[ch_r] = 1'b0; end
                4'hD: begin rd_next_s = '0; red_next_s[ch_r] = 1'b0; black_next_s[ch_r] = 1'b1; end
                4'hE: begin rd_next_s = '0; red_next_s[ch_r] = 1'b0; black_next_s[ch_r] = 1'b0; end
                4'hF: rd_next_s = CNT_W'({red_r[ch_r], err_r[ch_r], pend_r[ch_r], dir_r[ch_r]});
                default: rd_next_s = '0;
            endcase
        end else begin
            rd_next_s = rd_data_r;
        end
    end

    // Quadrature step classification per channel
    always_comb begin
        inc_s = '0;
        dec_s = '0;
        bad_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (step_delta(a_sync_r[SYNC_STAGES-1][i], b_sync_r[SYNC_STAGES-1][i],
                             a_prev_r[i], b_prev_r[i]))
                2'd1:    inc_s[i] = 1'b1;
                2'd3:    dec_s[i] = 1'b1;
                2'd2:    bad_s[i] = 1'b1;
                default: ;
            endcase
        end
    end

    // Input synchronisers, position counters and per-channel flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                a_sync_r[s] <= '0;
                b_sync_r[s] <= '0;
            end
            a_prev_r <= '0;
            b_prev_r <= '0;
            for (int i = 0; i < NUM_CH; i++) pos_r[i] <= '0;
            dir_r  <= '0;
            pend_r <= '0;
            err_r  <= '0;
        end else begin
            a_sync_r[0] <= cha;
            b_sync_r[0] <= chb;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                a_sync_r[s] <= a_sync_r[s-1];
                b_sync_r[s] <= b_sync_r[s-1];
            end
            a_prev_r <= a_sync_r[SYNC_STAGES-1];
            b_prev_r <= b_sync_r[SYNC_STAGES-1];
            for (int i = 0; i < NUM_CH; i++) begin
                // A clear in ACK beats a coincident step
                if (clr_pos_s[i])  pos_r[i] <= '0;
                else if (inc_s[i]) pos_r[i] <= pos_r[i] + CNT_ONE;
                else if (dec_s[i]) pos_r[i] <= pos_r[i] - CNT_ONE;
                if (inc_s[i])      dir_r[i] <= 1'b1;
                else if (dec_s[i]) dir_r[i] <= 1'b0;
                if (inc_s[i] || dec_s[i]) pend_r[i] <= 1'b1;
                else if (clr_flag_s[i])   pend_r[i] <= 1'b0;
                if (bad_s[i])           err_r[i] <= 1'b1;
                else if (clr_flag_s[i]) err_r[i] <= 1'b0;
            end
        end
    end

    // Registered bus read data, drive outputs and interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_r <= '0;
            red_r     <= '0;
            black_r   <= '0;
            int_r     <= 1'b0;
        end else begin
            rd_data_r <= rd_next_s;
            red_r     <= red_next_s;
            black_r   <= black_next_s;
            int_r     <= |pend_r;
        end
    end

    assign ready       = ready_r;
    assign rd_data     = rd_data_r;
    assign motor_red   = red_r;
    assign motor_black = black_r;
    assign interrupt   = int_r;

endmodule
